// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared encodings and defaults for the instruction-fetch front end
package ifetch_pkg;

  // Next-PC select encodings, shared with the main control decoder
  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/ifetch_npc.sv
// rtl/ifetch_npc.sv - combinational next-PC computation, reusable by a pipelined front end
module npc
  import ifetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [1:0]  PC_sel,
  input  logic        zero,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic        misalign
);

  logic [31:0] pc4;
  logic [31:0] br_off;
  logic        unused_opcode;

  assign pc4           = pc + 32'd4;
  assign br_off        = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign unused_opcode = &{1'b0, instr[31:26]};

  always_comb begin
    next_pc  = pc4;
    misalign = 1'b0;
    case (PC_sel)
      NPC_PLUS4:  next_pc = pc4;
      NPC_BRANCH: next_pc = zero ? (pc4 + br_off) : pc4;
      NPC_JUMP:   next_pc = {pc4[31:28], instr[25:0], 2'b00};
      NPC_JR: begin
        next_pc  = {jr_target[31:2], 2'b00};
        misalign = (jr_target[1:0] != 2'b00);
      end
      default:    next_pc = pc4;
    endcase
  end

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - PC owner, single-outstanding imem fetch, instruction register and retire handling
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic        instr_valid,
  output logic [31:0] pc,
  input  logic        retire,
  input  logic [1:0]  PC_sel,
  input  logic        zero,
  input  logic [31:0] jr_target,
  output logic        fetch_err,
  output logic [31:0] retired_cnt
);

  localparam logic [7:0] TCNT_MAX = 8'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [31:0] pc_r, pc_n;
  logic [31:0] instr_r, instr_n;
  logic [7:0]  tcnt, tcnt_n;
  logic        drop, drop_n;
  logic        err_r, err_n;
  logic [31:0] cnt_r, cnt_n;
  logic        req_r;
  logic        ivalid_r;
  logic [31:0] next_pc;
  logic        misalign;

  npc u_npc (
    .pc        (pc_r),
    .instr     (instr_r),
    .PC_sel    (PC_sel),
    .zero      (zero),
    .jr_target (jr_target),
    .next_pc   (next_pc),
    .misalign  (misalign)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_FETCH;
      pc_r     <= RESET_PC;
      instr_r  <= '0;
      tcnt     <= '0;
      drop     <= 1'b0;
      err_r    <= 1'b0;
      cnt_r    <= '0;
      req_r    <= 1'b1;
      ivalid_r <= 1'b0;
    end else begin
      state    <= state_n;
      pc_r     <= pc_n;
      instr_r  <= instr_n;
      tcnt     <= tcnt_n;
      drop     <= drop_n;
      err_r    <= err_n;
      cnt_r    <= cnt_n;
      req_r    <= (state_n == S_FETCH) && !drop_n;
      ivalid_r <= (state_n == S_EXEC);
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc_r;
    instr_n = instr_r;
    tcnt_n  = tcnt;
    drop_n  = 1'b0;
    err_n   = err_r;
    cnt_n   = cnt_r;
    case (state)
      S_FETCH: begin
        // The drop cycle after a timeout ignores rvalid; the request is reissued next cycle
        if (drop) begin
          tcnt_n = '0;
        end else if (imem_rvalid) begin
          instr_n = imem_rdata;
          tcnt_n  = '0;
          state_n = S_EXEC;
        end else if (tcnt == TCNT_MAX) begin
          err_n  = 1'b1;
          tcnt_n = '0;
          drop_n = 1'b1;
        end else begin
          tcnt_n = tcnt + 8'd1;
        end
      end
      S_EXEC: begin
        if (retire) begin
          pc_n    = next_pc;
          cnt_n   = cnt_r + 32'd1;
          state_n = S_FETCH;
          if (misalign) err_n = 1'b1;
        end
      end
      default: state_n = S_FETCH;
    endcase
  end

  assign imem_req    = req_r;
  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign instr       = instr_r;
  assign opcode      = instr_r[31:26];
  assign func        = instr_r[5:0];
  assign instr_valid = ivalid_r;
  assign fetch_err   = err_r;
  assign retired_cnt = cnt_r;

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - directed plus randomized self-checking bench for ifetch
module tb_ifetch;
  import ifetch_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_3000;
  localparam int          TO  = 16;

  logic        clk;
  logic        rstn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic        instr_valid;
  logic [31:0] pc;
  logic        retire;
  logic [1:0]  PC_sel;
  logic        zero;
  logic [31:0] jr_target;
  logic        fetch_err;
  logic [31:0] retired_cnt;

  ifetch #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .opcode      (opcode),
    .func        (func),
    .instr_valid (instr_valid),
    .pc          (pc),
    .retire      (retire),
    .PC_sel      (PC_sel),
    .zero        (zero),
    .jr_target   (jr_target),
    .fetch_err   (fetch_err),
    .retired_cnt (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: architectural state only
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_cnt;
  logic        m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc    = RPC;
    m_instr = '0;
    m_cnt   = '0;
    m_err   = 1'b0;
  endtask

  task automatic chk_reset();
    chk("rst_instr",  instr,       32'h0);
    chk("rst_opcode", opcode,      32'h0);
    chk("rst_func",   func,        32'h0);
    chk("rst_ivalid", instr_valid, 32'h0);
    chk("rst_req",    imem_req,    32'h1);
    chk("rst_addr",   imem_addr,   RPC);
    chk("rst_pc",     pc,          RPC);
    chk("rst_err",    fetch_err,   32'h0);
    chk("rst_cnt",    retired_cnt, 32'h0);
  endtask

  task automatic do_fetch(input int lat, input logic [31:0] word);
    for (int i = 0; i < lat; i++) begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      retire      = 1'($urandom);
      PC_sel      = 2'($urandom);
      zero        = 1'($urandom);
      jr_target   = $urandom;
      chk("wait_req",    imem_req,    32'h1);
      chk("wait_addr",   imem_addr,   m_pc);
      chk("wait_ivalid", instr_valid, 32'h0);
      tick();
    end
    retire      = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    chk("resp_req",  imem_req,  32'h1);
    chk("resp_addr", imem_addr, m_pc);
    tick();
    imem_rvalid = 1'b0;
    m_instr     = word;
    chk("f_ivalid", instr_valid, 32'h1);
    chk("f_instr",  instr,       word);
    chk("f_opcode", opcode,      word >> 26);
    chk("f_func",   func,        word & 32'h3F);
    chk("f_req",    imem_req,    32'h0);
    chk("f_pc",     pc,          m_pc);
    chk("f_err",    fetch_err,   m_err);
    chk("f_cnt",    retired_cnt, m_cnt);
  endtask

  task automatic do_retire(input logic [1:0] sel, input logic z, input logic [31:0] jr, input int hold);
    logic [31:0] pc4;
    logic [31:0] nxt;
    int          off;
    for (int i = 0; i < hold; i++) begin
      retire      = 1'b0;
      imem_rvalid = 1'($urandom);
      imem_rdata  = $urandom;
      tick();
      chk("hold_instr",  instr,       m_instr);
      chk("hold_ivalid", instr_valid, 32'h1);
      chk("hold_req",    imem_req,    32'h0);
      chk("hold_pc",     pc,          m_pc);
    end
    imem_rvalid = 1'b0;
    pc4 = m_pc + 32'd4;
    case (sel)
      2'd0: nxt = pc4;
      2'd1: begin
        off = int'($signed(m_instr[15:0]));
        nxt = z ? pc4 + 32'(off * 4) : pc4;
      end
      2'd2: nxt = (pc4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
      default: begin
        nxt = jr & 32'hFFFF_FFFC;
        if ((jr % 4) != 0) m_err = 1'b1;
      end
    endcase
    retire    = 1'b1;
    PC_sel    = sel;
    zero      = z;
    jr_target = jr;
    tick();
    retire = 1'b0;
    m_pc   = nxt;
    m_cnt  = m_cnt + 32'd1;
    chk("r_pc",     pc,          m_pc);
    chk("r_addr",   imem_addr,   m_pc);
    chk("r_req",    imem_req,    32'h1);
    chk("r_ivalid", instr_valid, 32'h0);
    chk("r_err",    fetch_err,   m_err);
    chk("r_cnt",    retired_cnt, m_cnt);
  endtask

  task automatic do_timeout();
    for (int i = 0; i < TO; i++) begin
      imem_rvalid = 1'b0;
      chk("to_req", imem_req, 32'h1);
      tick();
    end
    m_err = 1'b1;
    chk("to_drop_req",  imem_req,  32'h0);
    chk("to_err",       fetch_err, 32'h1);
    chk("to_drop_addr", imem_addr, m_pc);
    imem_rvalid = 1'b1;
    imem_rdata  = $urandom;
    tick();
    imem_rvalid = 1'b0;
    chk("to_reissue_req",  imem_req,    32'h1);
    chk("to_reissue_addr", imem_addr,   m_pc);
    chk("to_ignored_rv",   instr_valid, 32'h0);
  endtask

  task automatic async_reset();
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    chk_reset();
    @(negedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    logic [31:0] jr;
    logic [1:0]  sel;
    rstn        = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    retire      = 1'b0;
    PC_sel      = NPC_PLUS4;
    zero        = 1'b0;
    jr_target   = '0;
    model_reset();
    repeat (2) tick();
    chk_reset();
    @(negedge clk);
    rstn = 1'b1;

    // Zero-wait first fetch, then straight-line code
    do_fetch(0, 32'h3401_0005);
    chk("first_opcode", opcode, 32'h0D);
    do_retire(NPC_PLUS4, 1'b0, 32'h0, 0);
    for (int i = 0; i < 2; i++) begin
      do_fetch($urandom_range(0, 15), $urandom);
      do_retire(NPC_PLUS4, 1'($urandom), $urandom, $urandom_range(0, 3));
    end
    chk("line_pc", pc, 32'h0000_300C);
    chk("line_cnt", retired_cnt, 32'd3);

    do_fetch($urandom_range(0, 15), $urandom);
    do_retire(NPC_PLUS4, 1'b0, 32'h0, 1);
    do_fetch(2, 32'h10A5_FFFC);
    do_retire(NPC_BRANCH, 1'b1, 32'h0, 0);
    chk("beq_taken_pc", pc, 32'h0000_3004);

    // EXEC with five retired, then asynchronous reset
    do_fetch(1, $urandom);
    chk("pre_rst_cnt", retired_cnt, 32'd5);
    async_reset();

    do_fetch(3, 32'h0800_0C04);
    do_retire(NPC_JUMP, 1'b0, 32'h0, 0);
    chk("jump_3010", pc, 32'h0000_3010);
    do_fetch(0, 32'h10A5_FFFC);
    do_retire(NPC_BRANCH, 1'b0, 32'h0, 2);
    chk("beq_not_taken_pc", pc, 32'h0000_3014);
    do_fetch(5, 32'h0800_0C08);
    do_retire(NPC_JUMP, 1'b1, 32'h0, 0);
    do_fetch(0, 32'h0800_0C10);
    do_retire(NPC_JUMP, 1'b0, 32'h0, 0);
    chk("jump_3040", pc, 32'h0000_3040);
    do_fetch(4, 32'h0060_0008);
    do_retire(NPC_JR, 1'b0, 32'h0000_3103, 0);
    chk("jr_pc", pc, 32'h0000_3100);
    chk("jr_err", fetch_err, 32'h1);

    // Reset mid-fetch, then a silent memory
    async_reset();
    do_timeout();
    do_fetch(TO - 1, 32'h2402_0001);
    do_retire(NPC_PLUS4, 1'b0, 32'h0, 0);
    chk("to_recover_pc", pc, 32'h0000_3004);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) do_timeout();
      do_fetch($urandom_range(0, 15), $urandom);
      sel = 2'($urandom);
      jr  = $urandom;
      if ($urandom_range(0, 7) != 0) jr[1:0] = 2'b00;
      do_retire(sel, 1'($urandom), jr, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
